// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory arbiter and
//               engine-side blocks. Bank codes match address bits [18:16]
//               as decoded by the memory manager.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Bank select codes, address[18:16]
    localparam logic [2:0] BANK_GENERAL = 3'b000;
    localparam logic [2:0] BANK_IN0     = 3'b001;
    localparam logic [2:0] BANK_IN1     = 3'b010;
    localparam logic [2:0] BANK_IN2     = 3'b011;
    localparam logic [2:0] BANK_OUT0    = 3'b100;
    localparam logic [2:0] BANK_OUT1    = 3'b101;
    localparam logic [2:0] BANK_OUT2    = 3'b110;
    localparam logic [2:0] BANK_IO      = 3'b111;

    // Position of the bank field inside a byte address
    localparam int unsigned BANK_LSB = 16;

    typedef enum logic [0:0] {
        PRIO_CPU = 1'b0,
        PRIO_ENG = 1'b1
    } prio_state_t;

    typedef enum logic [0:0] {
        M_CPU = 1'b0,
        M_ENG = 1'b1
    } master_t;

    // The engine may only touch the image banks (IN*/OUT*).
    function automatic logic eng_bank_illegal(input logic [2:0] bank);
        return (bank == BANK_GENERAL) || (bank == BANK_IO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the two requester ports (CPU, engine), the shared
//               memory-manager port and the error flag of dmem_arbiter.
//   slave  : arbiter view (requests/mem_rdata/err_clr in; grants/read
//            returns/memory port/err out)
//   master : environment view (the reverse)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // CPU load/store unit (master 0)
    logic          cpu_req_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic          cpu_wren_i;
    logic          cpu_gnt_o;
    logic          cpu_rvalid_o;
    logic [DW-1:0] cpu_rdata_o;
    // Image-processing engine (master 1)
    logic          eng_req_i;
    logic [AW-1:0] eng_addr_i;
    logic [DW-1:0] eng_wdata_i;
    logic          eng_wren_i;
    logic          eng_gnt_o;
    logic          eng_rvalid_o;
    logic [DW-1:0] eng_rdata_o;
    // Memory-manager port
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_wren_o;
    logic [DW-1:0] mem_rdata_i;
    // Engine bank-violation flag
    logic          err_o;
    logic          err_clr_i;

    modport slave (
        input  cpu_req_i, cpu_addr_i, cpu_wdata_i, cpu_wren_i,
        input  eng_req_i, eng_addr_i, eng_wdata_i, eng_wren_i,
        input  mem_rdata_i, err_clr_i,
        output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        output eng_gnt_o, eng_rvalid_o, eng_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_wren_o, err_o
    );

    modport master (
        output cpu_req_i, cpu_addr_i, cpu_wdata_i, cpu_wren_i,
        output eng_req_i, eng_addr_i, eng_wdata_i, eng_wren_i,
        output mem_rdata_i, err_clr_i,
        input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        input  eng_gnt_o, eng_rvalid_o, eng_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_wren_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bank_check.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank_check
// Description : Combinational legality check for engine-side accesses.
//               Flags the GENERAL and IO banks, which the engine must not use.
//   bank_i    : address[18:16] of the engine access
//   illegal_o : 1 when the bank is off-limits to the engine
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank_check
    import dmem_pkg::*;
(
    input  logic [2:0] bank_i,
    output logic       illegal_o
);
    assign illegal_o = eng_bank_illegal(bank_i);
endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter in front of the data-memory manager.
//               CPU has priority; a starvation counter forces an engine win
//               after STARVE_LIMIT denied engine cycles. Read data (1-cycle
//               latency) is routed back to the issuing master. Engine
//               accesses to GENERAL/IO banks are granted but neutralised and
//               raise a sticky error.
//   CLK   : system clock, rising edge
//   RST_n : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave - requester ports, memory port, err flag
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               RST_n,
    dmem_arbiter_if.slave      bus
);

    localparam int unsigned    c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    prio_state_t        state_q, state_d;
    logic [c_cnt_w-1:0] wait_cnt_q, wait_cnt_d;
    logic               owner_valid_q, owner_valid_d;
    master_t            owner_master_q, owner_master_d;
    logic               owner_blocked_q, owner_blocked_d;
    logic               err_q, err_d;

    logic               w_cpu_gnt;
    logic               w_eng_gnt;
    logic               w_eng_illegal;
    logic [c_cnt_w-1:0] w_wait_inc;
    logic [AW-1:0]      w_mem_addr;
    logic [DW-1:0]      w_mem_wdata;
    logic               w_mem_wren;
    logic               w_cpu_rvalid;
    logic               w_eng_rvalid;

    dmem_bank_check u_bank_check (
        .bank_i    (bus.eng_addr_i[BANK_LSB+2:BANK_LSB]),
        .illegal_o (w_eng_illegal)
    );

    // ------------------------------------------------------------------
    // Grant decision. Gated by RST_n so no grant (and hence no memory
    // write) can leak out while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_eng_gnt = 1'b0;
        if (RST_n) begin
            if (state_q == PRIO_ENG) begin
                if (bus.eng_req_i)      w_eng_gnt = 1'b1;
                else if (bus.cpu_req_i) w_cpu_gnt = 1'b1;
            end else begin
                if (bus.cpu_req_i)      w_cpu_gnt = 1'b1;
                else if (bus.eng_req_i) w_eng_gnt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Priority state / starvation counter. An engine grant always resets
    // the counter and hands priority back to the CPU.
    // ------------------------------------------------------------------
    assign w_wait_inc = (wait_cnt_q == c_limit) ? wait_cnt_q
                                                : wait_cnt_q + c_cnt_w'(1);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (w_eng_gnt) begin
            state_d    = PRIO_CPU;
            wait_cnt_d = '0;
        end else if (bus.eng_req_i) begin
            wait_cnt_d = w_wait_inc;
            if ((state_q == PRIO_CPU) && (w_wait_inc == c_limit)) begin
                state_d = PRIO_ENG;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux. With no grant the CPU inputs are presented but the
    // write enable stays low. Illegal engine writes are suppressed.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_addr  = bus.cpu_addr_i;
        w_mem_wdata = bus.cpu_wdata_i;
        w_mem_wren  = 1'b0;
        if (w_eng_gnt) begin
            w_mem_addr  = bus.eng_addr_i;
            w_mem_wdata = bus.eng_wdata_i;
            w_mem_wren  = bus.eng_wren_i & ~w_eng_illegal;
        end else if (w_cpu_gnt) begin
            w_mem_wren  = bus.cpu_wren_i;
        end
    end

    // ------------------------------------------------------------------
    // Read owner tracking and sticky error (set beats clear).
    // ------------------------------------------------------------------
    always_comb begin
        owner_valid_d   = (w_cpu_gnt & ~bus.cpu_wren_i) | (w_eng_gnt & ~bus.eng_wren_i);
        owner_master_d  = w_eng_gnt ? M_ENG : M_CPU;
        owner_blocked_d = w_eng_gnt & w_eng_illegal;
        err_d           = (w_eng_gnt & w_eng_illegal) | (err_q & ~bus.err_clr_i);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q         <= PRIO_CPU;
            wait_cnt_q      <= '0;
            owner_valid_q   <= 1'b0;
            owner_master_q  <= M_CPU;
            owner_blocked_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            owner_valid_q   <= owner_valid_d;
            owner_master_q  <= owner_master_d;
            owner_blocked_q <= owner_blocked_d;
            err_q           <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_cpu_rvalid = owner_valid_q && (owner_master_q == M_CPU);
    assign w_eng_rvalid = owner_valid_q && (owner_master_q == M_ENG);

    assign bus.cpu_gnt_o    = w_cpu_gnt;
    assign bus.eng_gnt_o    = w_eng_gnt;
    assign bus.cpu_rvalid_o = w_cpu_rvalid;
    assign bus.eng_rvalid_o = w_eng_rvalid;
    assign bus.cpu_rdata_o  = w_cpu_rvalid ? bus.mem_rdata_i : '0;
    assign bus.eng_rdata_o  = (w_eng_rvalid && !owner_blocked_q) ? bus.mem_rdata_i : '0;
    assign bus.mem_addr_o   = w_mem_addr;
    assign bus.mem_wdata_o  = w_mem_wdata;
    assign bus.mem_wren_o   = w_mem_wren;
    assign bus.err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. Vector tables give the
//               expected grants per cycle; read returns are checked against a
//               queue of expected data derived from a reference memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic CLK   = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    typedef struct {
        logic        creq;
        logic        cwr;
        logic [31:0] caddr;
        logic [31:0] cwd;
        logic        ereq;
        logic        ewr;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic        clr;
        logic        want_cg;
        logic        want_eg;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_t;

    vec_t        tbl[$];
    rd_t         cpu_q[$];
    rd_t         eng_q[$];
    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        ram_loaded = 1'b0;
    logic        m_err      = 1'b0;
    int          checks     = 0;
    int          failures   = 0;
    int          cyc        = 0;

    // Compressed word index: bank field plus low word bits
    function automatic int idx(input logic [31:0] a);
        return int'({a[18:16], a[8:2]});
    endfunction

    function automatic logic [31:0] init_val(input int i);
        if (i == idx(32'h0000_0004)) return 32'h4444_0004;
        if (i == idx(32'h0000_0020)) return 32'hC0DE_0020;
        if (i == idx(32'h0000_0100)) return 32'h0BAD_0100;
        if (i == idx(32'h0001_0000)) return 32'hE001_0000;
        if (i == idx(32'h0002_0005)) return 32'h0000_00A5;
        if (i == idx(32'h0007_0000)) return 32'hFFFF_FFFF;
        return 32'h0;
    endfunction

    // Synchronous RAM behind the arbiter (1-cycle read latency)
    always @(posedge CLK) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (bus.mem_wren_o) begin
            ram[idx(bus.mem_addr_o)] <= bus.mem_wdata_o;
        end
        bus.mem_rdata_i <= ram[idx(bus.mem_addr_o)];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, want);
        end
    endtask

    function automatic vec_t mk(input logic creq, input logic cwr, input logic [31:0] caddr,
                                input logic [31:0] cwd, input logic ereq, input logic ewr,
                                input logic [31:0] eaddr, input logic [31:0] ewd,
                                input logic clr, input logic cg, input logic eg);
        vec_t v;
        v.creq = creq; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
        v.ereq = ereq; v.ewr = ewr; v.eaddr = eaddr; v.ewd = ewd;
        v.clr = clr; v.want_cg = cg; v.want_eg = eg;
        return v;
    endfunction

    function automatic vec_t idle(input logic clr);
        return mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, clr, 0, 0);
    endfunction
    function automatic vec_t cw(input logic [31:0] a, input logic [31:0] d);
        return mk(1, 1, a, d, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    endfunction
    function automatic vec_t cr(input logic [31:0] a);
        return mk(1, 0, a, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    endfunction
    function automatic vec_t er(input logic [31:0] a, input logic clr);
        return mk(0, 0, 32'h0, 32'h0, 1, 0, a, 32'h0, clr, 0, 1);
    endfunction
    function automatic vec_t ew(input logic [31:0] a, input logic [31:0] d);
        return mk(0, 0, 32'h0, 32'h0, 1, 1, a, d, 0, 0, 1);
    endfunction
    // Both masters reading continuously; eng_wins selects the expected winner
    function automatic vec_t both(input logic eng_wins);
        return mk(1, 0, 32'h20, 32'h0, 1, 0, 32'h0001_0000, 32'h0, 0, !eng_wins, eng_wins);
    endfunction

    function automatic logic bank_bad(input logic [31:0] a);
        return (a[18:16] == 3'b000) || (a[18:16] == 3'b111);
    endfunction

    task automatic drive(input vec_t v);
        bus.cpu_req_i   = v.creq;
        bus.cpu_wren_i  = v.cwr;
        bus.cpu_addr_i  = v.caddr;
        bus.cpu_wdata_i = v.cwd;
        bus.eng_req_i   = v.ereq;
        bus.eng_wren_i  = v.ewr;
        bus.eng_addr_i  = v.eaddr;
        bus.eng_wdata_i = v.ewd;
        bus.err_clr_i   = v.clr;
    endtask

    // One clock cycle: drive, then check grants, memory port, read returns
    task automatic step(input vec_t v);
        logic viol;
        logic want_v;
        rd_t  e;
        @(posedge CLK);
        #1;
        drive(v);
        @(negedge CLK);
        cyc++;
        viol = bank_bad(v.eaddr);

        want_v = (cpu_q.size() > 0) && (cpu_q[0].cyc == cyc - 1);
        chk("cpu_rvalid", {31'b0, bus.cpu_rvalid_o}, {31'b0, want_v});
        if (want_v) begin
            chk("cpu_rdata", bus.cpu_rdata_o, cpu_q[0].data);
            void'(cpu_q.pop_front());
        end else begin
            chk("cpu_rdata_idle", bus.cpu_rdata_o, 32'h0);
        end
        want_v = (eng_q.size() > 0) && (eng_q[0].cyc == cyc - 1);
        chk("eng_rvalid", {31'b0, bus.eng_rvalid_o}, {31'b0, want_v});
        if (want_v) begin
            chk("eng_rdata", bus.eng_rdata_o, eng_q[0].data);
            void'(eng_q.pop_front());
        end else begin
            chk("eng_rdata_idle", bus.eng_rdata_o, 32'h0);
        end

        chk("cpu_gnt", {31'b0, bus.cpu_gnt_o}, {31'b0, v.want_cg});
        chk("eng_gnt", {31'b0, bus.eng_gnt_o}, {31'b0, v.want_eg});
        chk("mem_wren", {31'b0, bus.mem_wren_o},
            {31'b0, v.want_eg ? (v.ewr & ~viol) : (v.want_cg & v.cwr)});
        chk("mem_addr", bus.mem_addr_o, v.want_eg ? v.eaddr : v.caddr);
        chk("mem_wdata", bus.mem_wdata_o, v.want_eg ? v.ewd : v.cwd);
        chk("err_o", {31'b0, bus.err_o}, {31'b0, m_err});

        if (v.want_cg) begin
            if (v.cwr) ref_mem[idx(v.caddr)] = v.cwd;
            else begin
                e.cyc = cyc; e.data = ref_mem[idx(v.caddr)];
                cpu_q.push_back(e);
            end
        end
        if (v.want_eg) begin
            if (v.ewr) begin
                if (!viol) ref_mem[idx(v.eaddr)] = v.ewd;
            end else begin
                e.cyc = cyc; e.data = viol ? 32'h0 : ref_mem[idx(v.eaddr)];
                eng_q.push_back(e);
            end
        end
        if (v.want_eg && viol) m_err = 1'b1;
        else if (v.clr)        m_err = 1'b0;
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

        // ---- Reset state: requests present but nothing granted ----
        RST_n = 1'b0;
        drive(mk(1, 1, 32'h10, 32'h1234, 1, 1, 32'h0001_0000, 32'h5678, 0, 0, 0));
        @(negedge CLK);
        chk("rst_cpu_gnt", {31'b0, bus.cpu_gnt_o}, 32'h0);
        chk("rst_eng_gnt", {31'b0, bus.eng_gnt_o}, 32'h0);
        chk("rst_mem_wren", {31'b0, bus.mem_wren_o}, 32'h0);
        chk("rst_cpu_rvalid", {31'b0, bus.cpu_rvalid_o}, 32'h0);
        chk("rst_eng_rvalid", {31'b0, bus.eng_rvalid_o}, 32'h0);
        chk("rst_err", {31'b0, bus.err_o}, 32'h0);
        @(negedge CLK);
        #1;
        drive(idle(0));
        RST_n = 1'b1;

        // ---- CPU only: 4 writes then 4 reads ----
        for (int i = 0; i < 4; i++) tbl.push_back(cw(32'(32'h10 + 4 * i), 32'(32'h1111_0000 + i)));
        for (int i = 0; i < 4; i++) tbl.push_back(cr(32'(32'h10 + 4 * i)));
        tbl.push_back(idle(0));
        run_tbl();

        // ---- Contention: CPU x4, ENG, repeated 3 times ----
        for (int i = 0; i < 15; i++) tbl.push_back(both((i % 5) == 4));
        tbl.push_back(idle(0));
        run_tbl();

        // ---- Engine read of IN1 then CPU read next cycle ----
        tbl.push_back(er(32'h0002_0005, 0));
        tbl.push_back(cr(32'h0000_0004));
        tbl.push_back(idle(0));
        tbl.push_back(idle(0));
        run_tbl();

        // ---- Bank violation, sticky error, set-beats-clear ----
        tbl.push_back(ew(32'h0000_0100, 32'hDEAD_BEEF));
        tbl.push_back(idle(0));
        tbl.push_back(cr(32'h0000_0100));
        tbl.push_back(er(32'h0007_0000, 1));
        tbl.push_back(idle(1));
        tbl.push_back(idle(0));
        run_tbl();

        // ---- Traffic while in PRIO_ENG ----
        for (int i = 0; i < 4; i++) tbl.push_back(both(0));
        tbl.push_back(cr(32'h20));
        tbl.push_back(cr(32'h4));
        tbl.push_back(both(1));
        for (int i = 0; i < 4; i++) tbl.push_back(both(0));
        tbl.push_back(er(32'h0001_0000, 0));
        tbl.push_back(both(0));
        tbl.push_back(idle(0));
        run_tbl();

        // ---- Reset right after a CPU read grant ----
        tbl.push_back(er(32'h0001_0000, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(both(0));
        run_tbl();
        @(posedge CLK);
        #1;
        RST_n = 1'b0;
        drive(mk(1, 1, 32'h10, 32'h5555, 1, 1, 32'h0001_0000, 32'h6666, 0, 0, 0));
        @(negedge CLK);
        cyc++;
        chk("rstmid_cpu_rvalid", {31'b0, bus.cpu_rvalid_o}, 32'h0);
        chk("rstmid_cpu_rdata", bus.cpu_rdata_o, 32'h0);
        chk("rstmid_eng_rvalid", {31'b0, bus.eng_rvalid_o}, 32'h0);
        chk("rstmid_cpu_gnt", {31'b0, bus.cpu_gnt_o}, 32'h0);
        chk("rstmid_eng_gnt", {31'b0, bus.eng_gnt_o}, 32'h0);
        chk("rstmid_mem_wren", {31'b0, bus.mem_wren_o}, 32'h0);
        cpu_q.delete();
        eng_q.delete();
        m_err = 1'b0;
        drive(idle(0));
        #2;
        RST_n = 1'b1;
        for (int i = 0; i < 5; i++) tbl.push_back(both(i == 4));
        tbl.push_back(idle(0));
        run_tbl();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
